// File: rtl/logic_unit_acc.sv
// logic_unit_acc: registered bitwise logic unit with pairwise and multi-beat
// accumulate (reduction) modes on valid/ready operand and result streams.
module logic_unit_acc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             MODE,
    input  logic             LAST,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             ONES,
    output logic [CNT_W-1:0] CNT
);

    localparam logic [0:0]       stIdle  = 1'b0;
    localparam logic [0:0]       stAccum = 1'b1;
    localparam logic [1:0]       opPass  = 2'b11;
    localparam logic [CNT_W-1:0] cntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] cntMax  = {CNT_W{1'b1}};

    // Base two-operand function selected by OP[1:0]
    function automatic logic [WIDTH-1:0] baseFn(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        case (op)
            2'b00:   baseFn = x & y;
            2'b01:   baseFn = x | y;
            2'b10:   baseFn = x ^ y;
            default: baseFn = x;
        endcase
    endfunction

    logic [0:0]       state, stateNext;
    logic [WIDTH-1:0] acc, accNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [2:0]       opLatch, opNext;
    logic             modeLatch, modeNext;
    logic             outValidReg, outValidNext;
    logic [WIDTH-1:0] yReg, resNext;
    logic             zeroReg, onesReg;
    logic [CNT_W-1:0] cntOutReg, cntOutNext;
    logic             loadOut;
    logic             accept;
    logic [WIDTH-1:0] pairNow, pairLatched, accumRes;
    logic [CNT_W-1:0] cntInc;

    assign in_ready  = !outValidReg || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = outValidReg;
    assign Y         = yReg;
    assign ZERO      = zeroReg;
    assign ONES      = onesReg;
    assign CNT       = cntOutReg;

    // First beat uses the live OP; later beats of a packet use the latched one
    assign pairNow     = baseFn(OP[1:0], A, B);
    assign pairLatched = baseFn(opLatch[1:0], A, B);
    assign accumRes    = (opLatch[1:0] == opPass) ? A : baseFn(opLatch[1:0], acc, pairLatched);
    assign cntInc      = (cnt == cntMax) ? cnt : cnt + cntOne;

    // Next-state, accumulator and result-load decisions
    always_comb begin
        stateNext  = state;
        accNext    = acc;
        cntNext    = cnt;
        opNext     = opLatch;
        modeNext   = modeLatch;
        loadOut    = 1'b0;
        resNext    = yReg;
        cntOutNext = cntOutReg;
        if (accept) begin
            if (state == stIdle) begin
                if (!MODE || LAST) begin
                    // Pairwise beat or single-beat packet
                    loadOut    = 1'b1;
                    resNext    = pairNow ^ {WIDTH{OP[2]}};
                    cntOutNext = cntOne;
                end else begin
                    accNext   = pairNow;
                    cntNext   = cntOne;
                    opNext    = OP;
                    modeNext  = MODE;
                    stateNext = stAccum;
                end
            end else begin
                cntNext = cntInc;
                if (LAST) begin
                    loadOut    = 1'b1;
                    resNext    = accumRes ^ {WIDTH{opLatch[2]}};
                    cntOutNext = cntInc;
                    stateNext  = stIdle;
                end else begin
                    accNext = accumRes;
                end
            end
        end
        // A load in the same cycle as a consume keeps the result valid
        outValidNext = loadOut || (outValidReg && !out_ready);
    end

    // Packet state: FSM, accumulator, beat counter and latched controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= stIdle;
            acc       <= '0;
            cnt       <= '0;
            opLatch   <= '0;
            modeLatch <= 1'b0;
        end else begin
            state     <= stateNext;
            acc       <= accNext;
            cnt       <= cntNext;
            opLatch   <= opNext;
            modeLatch <= modeNext;
        end
    end

    // Output register; flags derive from the value being loaded, not the old Y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValidReg <= 1'b0;
            yReg        <= '0;
            zeroReg     <= 1'b0;
            onesReg     <= 1'b0;
            cntOutReg   <= '0;
        end else begin
            outValidReg <= outValidNext;
            if (loadOut) begin
                yReg      <= resNext;
                zeroReg   <= (resNext == {WIDTH{1'b0}});
                onesReg   <= (resNext == {WIDTH{1'b1}});
                cntOutReg <= cntOutNext;
            end
        end
    end

endmodule

// File: doc/logic_unit_acc.md
# logic_unit_acc

Parametrised, registered bitwise logic unit that generalises the two-input AND gate to WIDTH-bit operands, eight selectable operations and a multi-beat accumulate (reduction) mode. Operands arrive on a valid/ready stream; results leave on a valid/ready stream from a single output register, with zero/all-ones flags and a beat count. It is the building block for the lab's datapath exercises and replaces the single-gate modules in new designs.

## Interface
- WIDTH, 8, operand and result width in bits (>= 1)
- CNT_W, 8, width of the beat counter CNT (>= 1)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- OP  input  3  OP[1:0]: 00 AND, 01 OR, 10 XOR, 11 PASS_A; OP[2]=1 inverts the result (NAND/NOR/XNOR/NOT_A)
- MODE  input  1  0 = pairwise, 1 = accumulate
- LAST  input  1  final beat of an accumulate packet (ignored when MODE=0)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- Y  output  WIDTH  result
- ZERO  output  1  Y == 0
- ONES  output  1  Y == all ones
- CNT  output  CNT_W  beats contributing to Y

## Operation
- Beat accepted when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
- Base function f(x,y) per OP[1:0]: x&y, x|y, x^y, x (PASS_A).
- States: IDLE (no packet open), ACCUM (packet open). Accumulator acc[WIDTH-1:0], counter cnt[CNT_W-1:0], latched op_l/mode_l.
- IDLE, accepted beat, MODE=0: output register loads Y = f(A,B) ^ {WIDTH{OP[2]}}, CNT = 1, out_valid = 1; stay IDLE.
- IDLE, accepted beat, MODE=1, LAST=0: acc <= f(A,B), cnt <= 1, latch OP and MODE; go ACCUM. No output.
- IDLE, accepted beat, MODE=1, LAST=1: single-beat packet, identical to MODE=0 result; stay IDLE.
- ACCUM, accepted beat: new = f(acc, f(A,B)) using latched OP[1:0]; for PASS_A new = A (last word wins). cnt increments, saturating at 2^CNT_W-1.
  - LAST=0: acc <= new, stay ACCUM.
  - LAST=1: output register loads Y = new ^ {WIDTH{op_l[2]}}, CNT = cnt+1 (saturated), out_valid = 1; go IDLE.
- OP and MODE inputs on non-first beats are ignored; packet uses values latched on first beat.
- ZERO/ONES are registered together with Y (derived from the value being loaded), never from a stale Y.
- out_valid clears when out_ready && !(new result loaded same cycle); simultaneous consume-and-load keeps out_valid = 1 with new data.
- Y/CNT/flags hold stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync-safe deassert by system): state IDLE, acc = 0, cnt = 0, out_valid = 0, Y = 0, ZERO = 0, ONES = 0, CNT = 0, latched op/mode = 0. in_ready = 1 in reset.
- Reset mid-packet: packet discarded, no output produced; next beat starts a new packet.
- Latency: result visible on out_valid/Y one cycle after the accepting edge of the pairwise or LAST beat.
- Throughput: one beat per cycle when out_ready held high; full-rate back-to-back pairwise results.
- Backpressure: while out_valid && !out_ready, in_ready = 0 for every beat (including non-LAST accumulate beats); no beat lost or duplicated.
- WIDTH=1 must work (ZERO = !Y, ONES = Y).

## Test plan
- Pairwise sweep, WIDTH=8, A=0xF0, B=0xCC, OP=0..7, out_ready=1 -> Y = C0, FC, 3C, F0, 3F, 03, C3, 0F one cycle after each beat, CNT=1, no bubbles.
- Accumulate AND, beats (A,B) = (FF,F7),(FE,FF),(7F,FF) LAST on third -> single output Y=0x76, CNT=3, ZERO=0; OP changed to XOR on beat 2 has no effect.
- Accumulate XOR with OP[2]=1, 4 beats A=01,02,04,08, B=00 -> Y=0xF0, CNT=4; then beats A=FF,B=FF single LAST with OP=AND -> Y=0xFF, ONES=1.
- Backpressure: out_ready low 5 cycles with result pending -> in_ready=0, Y stable; out_ready high -> result consumed, next beat accepted same cycle, out_valid stays 1.
- Reset mid-packet: 2 non-LAST accumulate beats, pulse rst_n low asynchronously -> all outputs 0 immediately; following pairwise beat yields correct Y, CNT=1.
- CNT_W=2, WIDTH=1: 6-beat OR packet -> CNT saturates at 3; WIDTH=1 exhaustive truth table of all OP values matches f with ZERO/ONES correct.
